// File: rtl/nibble_serial_sub_if.sv
// Operand/result handshake bundle for the nibble-serial subtractor.
// The master side supplies operands and consumes results; the slave side is the subtractor.
interface nibble_serial_sub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf, zero
    );
endinterface

// File: rtl/nibble_serial_sub.sv
// Serial subtractor: diff = a - b - bin, one 4-bit nibble per clock, LSB first,
// with lookahead borrow inside each nibble and a registered borrow between nibbles.
module nibble_serial_sub #(
    parameter int WIDTH = 16,
    localparam int NIB  = WIDTH / 4
) (
    input  logic              clk,
    input  logic              rst_n,
    nibble_serial_sub_if.slave bus
);
    localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             borrow_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] diff_q;
    logic [WIDTH-1:0] diff_d;
    logic             bout_q;
    logic             ovf_q;
    logic             zero_q;

    logic [3:0] a_nib;
    logic [3:0] b_nib;
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] nib_diff;
    logic [4:0] c;
    logic       last_nib;

    assign a_nib    = a_q[{cnt_q, 2'b00} +: 4];
    assign b_nib    = b_q[{cnt_q, 2'b00} +: 4];
    assign last_nib = (cnt_q == CW'(NIB - 1));

    // Subtraction as a + ~b + ~borrow: carry-in is the inverted borrow.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bit
            assign g[gi]        = a_nib[gi] & ~b_nib[gi];
            assign p[gi]        = a_nib[gi] ^ ~b_nib[gi];
            assign nib_diff[gi] = p[gi] ^ c[gi];
        end
    endgenerate

    assign c[0] = ~borrow_q;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

    // Full word including the nibble being finished this cycle, so flags see the final value.
    always_comb begin
        diff_d = diff_q;
        diff_d[{cnt_q, 2'b00} +: 4] = nib_diff;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        borrow_q <= bus.bin;
                        cnt_q    <= '0;
                        diff_q   <= '0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    diff_q   <= diff_d;
                    borrow_q <= ~c[4];
                    cnt_q    <= cnt_q + CW'(1);
                    if (last_nib) begin
                        cnt_q   <= '0;
                        bout_q  <= ~c[4];
                        ovf_q   <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                   (diff_d[WIDTH-1] != a_q[WIDTH-1]);
                        zero_q  <= ~|diff_d;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_nibble_serial_sub.sv
// Self-checking bench for nibble_serial_sub (WIDTH = 16): directed vectors, random
// operands against an arithmetic model, backpressure and reset abort.
module tb_nibble_serial_sub;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    nibble_serial_sub_if #(.WIDTH(W)) bus();

    nibble_serial_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the full operands.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                                  output logic [W-1:0] d, output logic bo, output logic ov,
                                  output logic z);
        longint ur;
        longint sr;
        ur = longint'(a) - longint'(b) - longint'(bin);
        sr = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
        d  = ur[W-1:0];
        bo = (ur < 0);
        ov = (sr > 32767) || (sr < -32768);
        z  = (d == '0);
    endfunction

    // Drives one operation, scrambles inputs while busy, returns latency and results.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input bit early_ready, output int lat, output logic [W-1:0] d,
                          output logic bo, output logic ov, output logic z);
        int n;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        bus.a         = a;
        bus.b         = b;
        bus.bin       = bin;
        bus.in_valid  = 1'b1;
        bus.out_ready = early_ready;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            bus.a        = W'($urandom);
            bus.b        = W'($urandom);
            bus.bin      = 1'($urandom);
            bus.in_valid = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        bus.in_valid = 1'b0;
        d  = bus.diff;
        bo = bus.bout;
        ov = bus.ovf;
        z  = bus.zero;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        $display("op a=%h b=%h bin=%0d -> diff=%h bout=%0d ovf=%0d zero=%0d lat=%0d",
                 a, b, bin, d, bo, ov, z, lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks += 6;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        if (bus.diff !== '0) begin errors++; $display("FAIL reset_diff got=%h exp=0000", bus.diff); end
        if (bus.bout !== 1'b0) begin errors++; $display("FAIL reset_bout got=%b exp=0", bus.bout); end
        if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf); end
        if (bus.zero !== 1'b0) begin errors++; $display("FAIL reset_zero got=%b exp=0", bus.zero); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [W-1:0] va [6];
        logic [W-1:0] vb [6];
        logic         vc [6];
        logic [W-1:0] ed [6];
        logic         eb [6];
        logic         eo [6];
        logic         ez [6];
        int           lat;
        logic [W-1:0] d;
        logic         bo, ov, z;
        va = '{16'h1234, 16'h0000, 16'h8000, 16'h7FFF, 16'hABCD, 16'hABCD};
        vb = '{16'h0234, 16'h0001, 16'h0001, 16'hFFFF, 16'hABCD, 16'hABCD};
        vc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        ed = '{16'h1000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF};
        eb = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        eo = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        ez = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], vc[i], 1'b0, lat, d, bo, ov, z);
            checks += 6;
            if (d !== ed[i]) begin errors++; $display("FAIL dir%0d_diff got=%h exp=%h", i, d, ed[i]); end
            if (bo !== eb[i]) begin errors++; $display("FAIL dir%0d_bout got=%b exp=%b", i, bo, eb[i]); end
            if (ov !== eo[i]) begin errors++; $display("FAIL dir%0d_ovf got=%b exp=%b", i, ov, eo[i]); end
            if (z !== ez[i]) begin errors++; $display("FAIL dir%0d_zero got=%b exp=%b", i, z, ez[i]); end
            if (lat !== NIB) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, NIB); end
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_release got in_ready=%b out_valid=%b exp 1/0", i, bus.in_ready, bus.out_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, d, ed;
        logic         bin, bo, ov, z, eb, eo, ez;
        int           lat;
        for (int i = 0; i < 40; i++) begin
            a   = W'($urandom);
            b   = W'($urandom);
            bin = 1'($urandom);
            if (i % 8 == 0) b = a;
            model(a, b, bin, ed, eb, eo, ez);
            run_op(a, b, bin, 1'($urandom), lat, d, bo, ov, z);
            checks += 5;
            if (d !== ed) begin errors++; $display("FAIL rnd%0d_diff got=%h exp=%h", i, d, ed); end
            if (bo !== eb) begin errors++; $display("FAIL rnd%0d_bout got=%b exp=%b", i, bo, eb); end
            if (ov !== eo) begin errors++; $display("FAIL rnd%0d_ovf got=%b exp=%b", i, ov, eo); end
            if (z !== ez) begin errors++; $display("FAIL rnd%0d_zero got=%b exp=%b", i, z, ez); end
            if (lat !== NIB) begin errors++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, NIB); end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] ed;
        logic         eb, eo, ez;
        int           n;
        int           bad;
        model(16'h5A5A, 16'hC3C3, 1'b1, ed, eb, eo, ez);
        bus.a = 16'h5A5A; bus.b = 16'hC3C3; bus.bin = 1'b1;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            bus.a = W'($urandom); bus.b = W'($urandom); bus.bin = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n !== NIB) begin errors++; $display("FAIL bp_latency got=%0d exp=%0d", n, NIB); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.diff !== ed ||
                bus.bout !== eb || bus.ovf !== eo || bus.zero !== ez) bad++;
            bus.a = W'($urandom); bus.in_valid = 1'($urandom);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold got %0d unstable cycles, diff=%h exp=%h", bad, bus.diff, ed);
        end
        $display("op a=5a5a b=c3c3 bin=1 -> diff=%h held 10 cycles", bus.diff);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got in_ready=%b out_valid=%b exp 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_reset_abort();
        int           lat;
        logic [W-1:0] d;
        logic         bo, ov, z;
        bus.a = 16'hFFFF; bus.b = 16'h0001; bus.bin = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid got=%b exp=0", bus.out_valid); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready got=%b exp=1", bus.in_ready); end
        if (bus.diff !== '0) begin errors++; $display("FAIL abort_diff got=%h exp=0000", bus.diff); end
        $display("op aborted by reset: out_valid=%b in_ready=%b", bus.out_valid, bus.in_ready);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(16'h0010, 16'h0001, 1'b0, 1'b0, lat, d, bo, ov, z);
        checks += 3;
        if (d !== 16'h000F) begin errors++; $display("FAIL abort_next_diff got=%h exp=000f", d); end
        if (bo !== 1'b0) begin errors++; $display("FAIL abort_next_bout got=%b exp=0", bo); end
        if (lat !== NIB) begin errors++; $display("FAIL abort_next_latency got=%0d exp=%0d", lat, NIB); end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nibble_serial_sub.md
Name: nibble_serial_sub

Overview:
- Multi-cycle unsigned/two's-complement subtractor: computes diff = a - b - bin one 4-bit nibble per clock, LSB nibble first.
- Each nibble uses lookahead-borrow logic internally; a registered borrow is chained between nibbles.
- Operands and results move over valid/ready handshakes, so the block can sit between an operand source and a result consumer in the datapath.
- Companion to the team's carry-lookahead adder: the area-lean subtract direction for wide words.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, derived nibble count; not to be overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b, bin are valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  result fields are valid
- out_ready  input  1  consumer accepts the result
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
- bout  output  1  final borrow-out: 1 when a < b + bin (unsigned)
- ovf  output  1  signed overflow of a - b - bin
- zero  output  1  diff == 0

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n).
  - Values while rst_n = 0: state IDLE, in_ready = 1, out_valid = 0, diff = 0, bout = 0, ovf = 0, zero = 0, nibble counter = 0, borrow register = 0.
  - Asserting rst_n mid-operation aborts the operation; no partial result is ever presented.
- FSM states:
  - IDLE: in_ready = 1. On in_valid & in_ready at a rising edge:
    - latch a, b;
    - borrow register <= bin;
    - counter <= 0;
    - go to BUSY.
  - BUSY: in_ready = 0. Each cycle processes nibble i = counter:
    - d_i = a[4i+3:4i] + ~b[4i+3:4i] + ~borrow; the 4-bit result is diff nibble i.
    - New borrow = ~(carry out of the nibble).
    - Counter increments.
    - When counter == NIB-1, go to DONE; out_valid rises at that same edge.
  - DONE: out_valid = 1; diff, bout, ovf, zero held stable.
    - On out_valid & out_ready at a rising edge: out_valid <= 0, go to IDLE.
    - in_ready is 1 in the following cycle.
- Latency: accept at edge k; out_valid is high from edge k+NIB (4 cycles for WIDTH = 16). Throughput is at most one operation per NIB+2 cycles.
- Handshake rules:
  - in_valid is ignored outside IDLE.
  - Once out_valid is asserted, result fields must not change until the handshake completes.
  - out_ready may be held low indefinitely with no loss.
  - out_ready being high before out_valid has no effect.
- Flags, registered on the transition into DONE:
  - bout = final borrow.
  - ovf = (a[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1]), using the latched a, b.
  - zero = ~|diff.
- Arithmetic: result wraps modulo 2^WIDTH. bin = 1 with a == b gives diff = all ones and bout = 1.
- WIDTH = 4: BUSY lasts one cycle; behaviour is otherwise identical.
- Latched operands are unaffected by input changes after acceptance.

Test Plan:
- WIDTH = 16; a = 0x1234, b = 0x0234, bin = 0 -> after 4 cycles: diff = 0x1000, bout = 0, ovf = 0, zero = 0.
- a = 0x0000, b = 0x0001, bin = 0 -> diff = 0xFFFF, bout = 1, ovf = 0. Borrow ripples through all 4 nibbles.
- a = 0x8000, b = 0x0001 -> diff = 0x7FFF, ovf = 1, bout = 0. Also a = 0x7FFF, b = 0xFFFF -> diff = 0x8000, ovf = 1, bout = 1.
- a = b = 0xABCD, bin = 0 -> diff = 0, zero = 1, bout = 0. Same operands with bin = 1 -> diff = 0xFFFF, bout = 1, zero = 0.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid rises -> results stable and in_ready = 0 throughout. Change a and b during BUSY -> result unaffected. in_ready returns one cycle after the handshake.
- Reset abort: pull rst_n low during the second BUSY cycle -> out_valid = 0 and in_ready = 1 immediately (asynchronously). After release, a new operation 0x0010 - 0x0001 gives diff = 0x000F with correct latency.
